ibex_fpga_bus_gpio: RTL
=======================

// Module: ibex_fpga_bus_gpio
// PURPOSE
//  - Parametrised bus fabric for the FPGA top.
//  - Arbitrates the Ibex instr and data ports onto one single-port SRAM port.
//  - Decodes a memory-mapped GPIO output register of GpioWidth bits.
//  - Returns an error response for unmapped addresses.
//  - Sits between ibex_core and ram_1p and drives the board LEDs/GPIO.
//  - Adds bounded-starvation arbitration and correct per-port rvalid/err routing.
// PARAMETERS
//  MemSize        65536         SRAM bytes, power of two, >= 4
//  MemStart       32'h00000000  SRAM base, aligned to MemSize
//  GpioStart      32'h80000000  GPIO base, 16-byte window, 16-byte aligned
//  GpioWidth      16            GPIO output bits, 1..32
//  MaxInstrStreak 4             max consecutive instr wins over a waiting data req, >= 1
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          synchronous active-low reset
//  instr_req_i    in   1          fetch request
//  instr_addr_i   in   32         fetch byte address
//  instr_gnt_o    out  1          fetch accepted this cycle
//  instr_rvalid_o out  1          fetch response valid
//  instr_rdata_o  out  32         fetch data
//  instr_err_o    out  1          fetch error, valid with rvalid
//  data_req_i     in   1          load/store request
//  data_we_i      in   1          1 = store
//  data_be_i      in   4          byte enables
//  data_addr_i    in   32         byte address
//  data_wdata_i   in   32         store data
//  data_gnt_o     out  1          data accepted this cycle
//  data_rvalid_o  out  1          data response valid (loads and stores)
//  data_rdata_o   out  32         load data
//  data_err_o     out  1          data error, valid with rvalid
//  mem_req_o      out  1          SRAM access
//  mem_we_o       out  1          SRAM write
//  mem_be_o       out  4          SRAM byte enables
//  mem_addr_o     out  32         SRAM byte offset (addr - MemStart)
//  mem_wdata_o    out  32         SRAM write data
//  mem_rdata_i    in   32         SRAM read data, one cycle after mem_req_o
//  gpio_o         out  GpioWidth  GPIO output register
// BEHAVIOUR
//  - Clock and reset: one clock, clk_i. rst_ni is synchronous and active-low.
//  - Reset values: all gnt/rvalid/err/mem_* outputs 0, rdata 0, gpio_o 0, streak counter 0.
//  - A response pending at reset is dropped.
//  - Grant: combinational, same cycle as the request.
//  - At most one port is granted per cycle. Every request is granted when selected.
//  - Arbitration when both req=1:
//    - instr wins unless streak == MaxInstrStreak; then data wins.
//    - With a single requester, that requester wins.
//  - Streak counter:
//    - +1 (saturating) when instr is granted while data_req_i=1.
//    - Cleared on a data grant or when data_req_i=0.
//  - Decode of the granted address:
//    - MEM: (addr & ~(MemSize-1)) == MemStart.
//    - GPIO: addr[31:4] == GpioStart[31:4].
//    - Anything else: ERR.
//    - Instr fetch from GPIO is ERR.
//  - MEM grant: mem_req_o=1 the same cycle, with we/be/wdata from data (instr: we=0, be=0).
//    mem_req_o=0 for GPIO and ERR.
//  - Response: rvalid exactly 1 cycle after gnt, on the granted port only.
//    - Source and decode type are registered on gnt.
//    - MEM: rdata = mem_rdata_i.
//    - GPIO: rdata = zero-extended register.
//    - ERR: err=1, rdata=0.
//    - Stores also get rvalid; rdata is then 0 for GPIO and ERR.
//    - Back-to-back grants give back-to-back rvalids.
//  - GPIO offset 0x0 (OUT), read/write:
//    - Byte lane i is written only when be[i]=1.
//    - Bits >= GpioWidth read 0 and ignore writes.
//    - New value appears on gpio_o the cycle after gnt.
//  - GPIO offsets 0x4-0xC without the optional feature: ERR; gpio_o unchanged.
//  - Address bits [1:0] are ignored (word access).
// CONFIGURATION
//  - Macro: IBEX_FPGA_GPIO_SETCLR_EN.
//  - Defined:
//    - 0x4 SET: gpio |= wdata & bytemask.
//    - 0x8 CLR: gpio &= ~(wdata & bytemask).
//    - Both read as 0 with no error. 0xC stays ERR.
//  - Undefined: 0x4, 0x8 and 0xC are ERR (err=1, no register change).
// TESTING
//  - Reset: hold rst_ni=0 for 3 cycles with requests active -> all gnt/rvalid/mem_req_o 0, gpio_o=0.
//  - Fetch 0x80 with mem_rdata_i=0x00000013 -> instr_gnt_o same cycle, mem_addr_o=0x80,
//    instr_rvalid_o next cycle with rdata 0x13, err=0.
//  - Store 0x0000A5A5, be=0011 to 0x80000000 -> gpio_o=0xA5A5 next cycle.
//    Load back -> rdata 0x0000A5A5. Store be=0010 of 0xFFFFFFFF -> gpio_o=0xFFA5.
//  - Both requesting continuously, MaxInstrStreak=4 -> grant pattern I,I,I,I,D repeating.
//    Data waits no more than 4 cycles.
//  - Load 0x40000000 and fetch 0x80000000 -> gnt, then rvalid with err=1, rdata=0,
//    mem_req_o never asserted.
//  - With IBEX_FPGA_GPIO_SETCLR_EN: gpio=0x00F0; SET 0x000F -> 0x00FF; CLR 0x00F0 -> 0x000F.
//    Without the macro the same SET store returns err=1 and gpio_o stays 0x00F0.

Source files
------------

// File: rtl/ibex_fpga_bus_gpio.sv
// Bus fabric for the Ibex FPGA top: arbitrates instr/data onto one SRAM port and decodes a GPIO
// output register. Define IBEX_FPGA_GPIO_SETCLR_EN to enable the SET (0x4) / CLR (0x8) aliases.
module ibex_fpga_bus_gpio #(
  parameter int unsigned MemSize        = 65536,
  parameter logic [31:0] MemStart       = 32'h0000_0000,
  parameter logic [31:0] GpioStart      = 32'h8000_0000,
  parameter int unsigned GpioWidth      = 16,
  parameter int unsigned MaxInstrStreak = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_req_i,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i,
  output logic [GpioWidth-1:0] gpio_o
);

`ifdef IBEX_FPGA_GPIO_SETCLR_EN
  localparam bit SetClrEn = 1'b1;
`else
  localparam bit SetClrEn = 1'b0;
`endif

  localparam int unsigned StreakW   = $clog2(MaxInstrStreak + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxInstrStreak);
  localparam logic [31:0] MemMask   = ~(32'(MemSize) - 32'd1);

  localparam logic [1:0] RspMem  = 2'd0;
  localparam logic [1:0] RspGpio = 2'd1;
  localparam logic [1:0] RspErr  = 2'd2;

  logic [StreakW-1:0]   streak_q, streak_d;
  logic [GpioWidth-1:0] gpio_q, gpio_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_instr_q, rsp_instr_d;
  logic [1:0]           rsp_type_q, rsp_type_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;

  logic                 instr_win, instr_sel, data_sel, any_sel;
  logic [31:0]          sel_addr;
  logic                 hit_mem, hit_gpio, mem_req;
  logic [31:0]          byte_mask;
  logic [GpioWidth-1:0] wr_mask, wr_data;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err, rsp_ok;

  // Instr keeps priority until it has starved a waiting data request MaxInstrStreak times.
  assign instr_win = instr_req_i & (~data_req_i | (streak_q != StreakMax));
  assign instr_sel = rst_ni & instr_win;
  assign data_sel  = rst_ni & data_req_i & ~instr_win;
  assign any_sel   = instr_sel | data_sel;

  assign sel_addr  = data_sel ? data_addr_i : instr_addr_i;
  assign hit_mem   = (sel_addr & MemMask) == MemStart;
  assign hit_gpio  = sel_addr[31:4] == GpioStart[31:4];

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      byte_mask[8*b +: 8] = {8{data_be_i[b]}};
    end
  end

  assign wr_mask = byte_mask[GpioWidth-1:0];
  assign wr_data = data_wdata_i[GpioWidth-1:0] & wr_mask;

  always_comb begin
    gpio_d      = gpio_q;
    rsp_valid_d = any_sel;
    rsp_instr_d = instr_sel;
    rsp_type_d  = RspErr;
    rsp_rdata_d = '0;
    mem_req     = 1'b0;
    if (any_sel) begin
      if (hit_mem) begin
        rsp_type_d = RspMem;
        mem_req    = 1'b1;
      end else if (hit_gpio && data_sel) begin
        unique case (sel_addr[3:2])
          2'd0: begin
            rsp_type_d = RspGpio;
            if (data_we_i) begin
              gpio_d = (gpio_q & ~wr_mask) | wr_data;
            end else begin
              rsp_rdata_d = 32'(gpio_q);
            end
          end
          2'd1: begin
            if (SetClrEn) begin
              rsp_type_d = RspGpio;
              if (data_we_i) gpio_d = gpio_q | wr_data;
            end
          end
          2'd2: begin
            if (SetClrEn) begin
              rsp_type_d = RspGpio;
              if (data_we_i) gpio_d = gpio_q & ~wr_data;
            end
          end
          default: rsp_type_d = RspErr;
        endcase
      end
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!data_req_i || data_sel) begin
      streak_d = '0;
    end else if (instr_sel && (streak_q != StreakMax)) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      streak_q    <= '0;
      gpio_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= 1'b0;
      rsp_type_q  <= RspErr;
      rsp_rdata_q <= '0;
    end else begin
      streak_q    <= streak_d;
      gpio_q      <= gpio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_type_q  <= rsp_type_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign instr_gnt_o = instr_sel;
  assign data_gnt_o  = data_sel;

  assign mem_req_o   = mem_req;
  assign mem_we_o    = mem_req & data_sel & data_we_i;
  assign mem_be_o    = (mem_req && data_sel) ? data_be_i : 4'b0000;
  assign mem_addr_o  = mem_req ? (sel_addr - MemStart) : 32'h0;
  assign mem_wdata_o = (mem_req && data_sel) ? data_wdata_i : 32'h0;

  // Gating with rst_ni drops a response that is still pending when reset asserts.
  assign rsp_ok    = rst_ni & rsp_valid_q;
  assign rsp_err   = rsp_type_q == RspErr;
  assign rsp_rdata = (rsp_type_q == RspMem) ? mem_rdata_i : rsp_rdata_q;

  assign instr_rvalid_o = rsp_ok & rsp_instr_q;
  assign instr_err_o    = instr_rvalid_o & rsp_err;
  assign instr_rdata_o  = instr_rvalid_o ? rsp_rdata : 32'h0;

  assign data_rvalid_o  = rsp_ok & ~rsp_instr_q;
  assign data_err_o     = data_rvalid_o & rsp_err;
  assign data_rdata_o   = data_rvalid_o ? rsp_rdata : 32'h0;

  assign gpio_o = gpio_q;

endmodule
